// File: rtl/demux_16bit_1i_4o_buf_pkg.sv
// Shared constants and types for the 16-bit 1-in/4-out buffered demux.
// Channel indices, default widths and the select decoder live here.
package demux_16bit_1i_4o_buf_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_COUNT_W = 8;
   localparam int N_CH        = 4;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

   function automatic logic [N_CH-1:0] sel_onehot(input logic [1:0] sel);
      logic [N_CH-1:0] vec;
      vec      = '0;
      vec[sel] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/demux_16bit_1i_4o_buf_chan.sv
// One output channel: a single-entry holding register with valid/ready
// handshake and a free-running count of words taken by the consumer.
module demux_chan_buf
   import demux_16bit_1i_4o_buf_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DATA_W-1:0]  din,
   output logic               valid,
   input  logic               ready,
   output logic [DATA_W-1:0]  r,
   output logic [COUNT_W-1:0] cnt
);

   buf_state_e         state_q;
   logic [DATA_W-1:0]  r_q;
   logic [COUNT_W-1:0] cnt_q;
   logic [COUNT_W-1:0] cnt_d;
   logic               deliver;

   assign deliver = (state_q == FULL) & ready;
   assign cnt_d   = cnt_q + COUNT_W'(1);

   // A load wins over a drain, so a same-cycle drain+load stays FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         r_q     <= '0;
         cnt_q   <= '0;
      end else begin
         if (load) begin
            state_q <= FULL;
            r_q     <= din;
         end else if (deliver) begin
            state_q <= EMPTY;
         end
         if (deliver) begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign valid = (state_q == FULL);
   assign r     = r_q;
   assign cnt   = cnt_q;

endmodule

// File: rtl/demux_16bit_1i_4o_buf.sv
// Buffered 1-to-4 word demux: steers a valid/ready input word into one of
// four single-entry output channels selected by s.
module demux_16bit_1i_4o_buf
   import demux_16bit_1i_4o_buf_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         s,
   input  logic [DATA_W-1:0]  din,
   output logic [N_CH-1:0]    out_valid,
   input  logic [N_CH-1:0]    out_ready,
   output logic [DATA_W-1:0]  ra,
   output logic [DATA_W-1:0]  rb,
   output logic [DATA_W-1:0]  rc,
   output logic [DATA_W-1:0]  rd,
   output logic [COUNT_W-1:0] cnt_a,
   output logic [COUNT_W-1:0] cnt_b,
   output logic [COUNT_W-1:0] cnt_c,
   output logic [COUNT_W-1:0] cnt_d
);

   logic [N_CH-1:0]    valid_vec;
   logic [N_CH-1:0]    load_vec;
   logic               accept;
   logic [DATA_W-1:0]  r_arr   [N_CH];
   logic [COUNT_W-1:0] cnt_arr [N_CH];

   // Only the selected channel gates acceptance; held low during reset.
   assign in_ready = rst_n & (~valid_vec[s] | out_ready[s]);
   assign accept   = in_valid & in_ready;
   assign load_vec = accept ? sel_onehot(s) : '0;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         demux_chan_buf #(
            .DATA_W  (DATA_W),
            .COUNT_W (COUNT_W)
         ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_vec[gi]),
            .din   (din),
            .valid (valid_vec[gi]),
            .ready (out_ready[gi]),
            .r     (r_arr[gi]),
            .cnt   (cnt_arr[gi])
         );
      end
   endgenerate

   assign out_valid = valid_vec;
   assign ra        = r_arr[CH_A];
   assign rb        = r_arr[CH_B];
   assign rc        = r_arr[CH_C];
   assign rd        = r_arr[CH_D];
   assign cnt_a     = cnt_arr[CH_A];
   assign cnt_b     = cnt_arr[CH_B];
   assign cnt_c     = cnt_arr[CH_C];
   assign cnt_d     = cnt_arr[CH_D];

endmodule
